// File: rtl/dmem_line_responder_if.sv
// Cache-line memory bus: the data cache controller is the master, the line responder the slave.
// Requests are level signals held until the one-cycle DDATA_ready pulse.
interface dmem_line_responder_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 27
);
  logic              DDATA_ren;
  logic              DDATA_wen;
  logic [ADDR_W-1:0] DDATA_addr;
  logic [LINE_W-1:0] DDATA_wdata;
  logic [LINE_W-1:0] DDATA_rdata;
  logic              DDATA_ready;
  logic              DDATA_err;

  modport master (
    output DDATA_ren, DDATA_wen, DDATA_addr, DDATA_wdata,
    input  DDATA_rdata, DDATA_ready, DDATA_err
  );

  modport slave (
    input  DDATA_ren, DDATA_wen, DDATA_addr, DDATA_wdata,
    output DDATA_rdata, DDATA_ready, DDATA_err
  );
endinterface

// File: rtl/dmem_line_responder.sv
// Line-addressed backing store answering one read/write per transaction with a LATENCY-cycle ready pulse.
// No pipelining; requests are ignored while busy. DMEM_RANGE_CHK_EN enables out-of-range detection.
module dmem_line_responder #(
  parameter int LINE_W  = 256,
  parameter int ADDR_W  = 27,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input logic                  clk_i,
  input logic                  start_i,
  dmem_line_responder_if.slave bus_io
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              ready_q;
  logic              err_q;
  logic              enter_done;
  logic              oor;
  logic              mem_we;
  logic [IDX_W-1:0]  idx;

  logic [LINE_W-1:0] memory [0:DEPTH-1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    enter_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus_io.DDATA_ren || bus_io.DDATA_wen) begin
          addr_d  = bus_io.DDATA_addr;
          wdata_d = bus_io.DDATA_wdata;
          wr_d    = bus_io.DDATA_wen;  // write wins when both are raised
          if (LATENCY == 1) begin
            state_d    = ST_DONE;
            cnt_d      = '0;
            enter_done = 1'b1;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d    = ST_DONE;
          enter_done = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The _d request fields equal the latched ones in BUSY and the live bus in IDLE (LATENCY==1).
  assign idx = addr_d[IDX_W-1:0];

`ifdef DMEM_RANGE_CHK_EN
  assign oor = |addr_d[ADDR_W-1:IDX_W];
`else
  logic unused_addr_hi;
  assign oor            = 1'b0;
  assign unused_addr_hi = ^addr_d[ADDR_W-1:IDX_W];
`endif

  assign rdata_d = wr_d ? wdata_d : (oor ? '0 : memory[idx]);
  assign mem_we  = enter_done && wr_d && !oor && start_i;

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      ready_q <= enter_done;
      err_q   <= enter_done && oor;
      if (enter_done) begin
        rdata_q <= rdata_d;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      memory[idx] <= wdata_d;
    end
  end

  assign bus_io.DDATA_rdata = rdata_q;
  assign bus_io.DDATA_ready = ready_q;
  assign bus_io.DDATA_err   = err_q;
endmodule

// File: tb/tb_dmem_line_responder.sv
// Scoreboard bench: drivers push expected responses, negedge monitors pop on every ready pulse.
module tb_dmem_line_responder;
  localparam int LW = 256;
  localparam int AW = 27;

  typedef struct {
    logic [LW-1:0] d;
    logic          e;
    int            at;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t m0, m1;
  bit   prev0, prev1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_line_responder_if #(.LINE_W(LW), .ADDR_W(AW)) b0 ();
  dmem_line_responder_if #(.LINE_W(LW), .ADDR_W(AW)) b1 ();

  dmem_line_responder #(.LINE_W(LW), .ADDR_W(AW), .DEPTH(512), .LATENCY(10)) dut (
    .clk_i(clk), .start_i(rst_n), .bus_io(b0)
  );
  dmem_line_responder #(.LINE_W(LW), .ADDR_W(AW), .DEPTH(512), .LATENCY(1)) dut1 (
    .clk_i(clk), .start_i(rst_n), .bus_io(b1)
  );

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (b0.DDATA_ready === 1'b1) begin
        chk("b0_pulse_width", LW'(prev0), '0);
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL b0_unexpected_ready: got ready at cycle %0d expected none", cyc);
        end else begin
          m0 = q0.pop_front();
          chk("b0_rdata", b0.DDATA_rdata, m0.d);
          chk("b0_err", LW'(b0.DDATA_err), LW'(m0.e));
          chk("b0_ready_cycle", LW'(cyc), LW'(m0.at));
        end
      end
      prev0 = (b0.DDATA_ready === 1'b1);
    end else prev0 = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (b1.DDATA_ready === 1'b1) begin
        chk("b1_pulse_width", LW'(prev1), '0);
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL b1_unexpected_ready: got ready at cycle %0d expected none", cyc);
        end else begin
          m1 = q1.pop_front();
          chk("b1_rdata", b1.DDATA_rdata, m1.d);
          chk("b1_err", LW'(b1.DDATA_err), LW'(m1.e));
          chk("b1_ready_cycle", LW'(cyc), LW'(m1.at));
        end
      end
      prev1 = (b1.DDATA_ready === 1'b1);
    end else prev1 = 1'b0;
  end

  task automatic drive(input bit sel, input bit ren, input bit wen,
                       input logic [AW-1:0] a, input logic [LW-1:0] d);
    if (sel) begin
      b1.DDATA_ren = ren; b1.DDATA_wen = wen; b1.DDATA_addr = a; b1.DDATA_wdata = d;
    end else begin
      b0.DDATA_ren = ren; b0.DDATA_wen = wen; b0.DDATA_addr = a; b0.DDATA_wdata = d;
    end
  endtask

  // Called at a negedge just before driving: acceptance is the next posedge.
  task automatic expect_resp(input bit sel, input logic [LW-1:0] d, input bit e, input int at);
    exp_t x;
    x.d = d; x.e = e; x.at = at;
    if (sel) q1.push_back(x);
    else q0.push_back(x);
  endtask

  task automatic wait_ready(input bit sel);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if ((sel ? b1.DDATA_ready : b0.DDATA_ready) === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got no ready on bus %0d expected one within 100 cycles", sel);
    end
  endtask

  task automatic txn(input bit sel, input bit ren, input bit wen, input logic [AW-1:0] a,
                     input logic [LW-1:0] d, input logic [LW-1:0] exp_d, input bit exp_e,
                     input int lat, input bit chg);
    @(negedge clk);
    expect_resp(sel, exp_d, exp_e, cyc + lat);
    drive(sel, ren, wen, a, d);
    if (chg) begin
      repeat (2) @(negedge clk);
      drive(sel, ren, wen, 27'h3, 256'hDEAD);
    end
    wait_ready(sel);
    drive(sel, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    logic [LW-1:0] exp_oor_d;
    bit            exp_oor_e;
`ifdef DMEM_RANGE_CHK_EN
    exp_oor_d = '0;      exp_oor_e = 1'b1;
`else
    exp_oor_d = 256'h5;  exp_oor_e = 1'b0;
`endif
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    #1 rst_n = 1'b0;
    dut.memory[0]  = 256'h5;
    dut.memory[3]  = 256'h33;
    dut.memory[7]  = 256'h77;
    dut1.memory[9] = 256'h99;
    repeat (2) @(negedge clk);
    chk("rst_b0_rdata", b0.DDATA_rdata, '0);
    chk("rst_b0_ready", LW'(b0.DDATA_ready), '0);
    chk("rst_b0_err", LW'(b0.DDATA_err), '0);
    chk("rst_b1_rdata", b1.DDATA_rdata, '0);
    chk("rst_b1_ready", LW'(b1.DDATA_ready), '0);
    chk("rst_b1_err", LW'(b1.DDATA_err), '0);
    rst_n = 1'b1;

    txn(1'b0, 1'b1, 1'b0, 27'h0,  '0,        256'h5,    1'b0, 10, 1'b0);
    txn(1'b0, 1'b0, 1'b1, 27'h20, 256'hA5A5, 256'hA5A5, 1'b0, 10, 1'b0);

    // Request held through DONE: re-accepted after one IDLE cycle, pulses LATENCY+1 apart.
    @(negedge clk);
    expect_resp(1'b0, 256'hA5A5, 1'b0, cyc + 10);
    expect_resp(1'b0, 256'hA5A5, 1'b0, cyc + 21);
    drive(1'b0, 1'b1, 1'b0, 27'h20, '0);
    wait_ready(1'b0);
    wait_ready(1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, '0);

    txn(1'b0, 1'b0, 1'b1, 27'h20, 256'hBEEF, 256'hBEEF, 1'b0, 10, 1'b1);
    txn(1'b0, 1'b1, 1'b0, 27'h3,  '0,        256'h33,   1'b0, 10, 1'b0);
    txn(1'b0, 1'b1, 1'b0, 27'h20, '0,        256'hBEEF, 1'b0, 10, 1'b0);
    txn(1'b0, 1'b1, 1'b1, 27'h5,  256'h1,    256'h1,    1'b0, 10, 1'b0);
    txn(1'b0, 1'b1, 1'b0, 27'h5,  '0,        256'h1,    1'b0, 10, 1'b0);

    // Reset four edges after accepting a write to line 7.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 27'h7, 256'hFFFF);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_rdata", b0.DDATA_rdata, '0);
    chk("abort_ready", LW'(b0.DDATA_ready), '0);
    chk("abort_err", LW'(b0.DDATA_err), '0);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    txn(1'b0, 1'b1, 1'b0, 27'h7,   '0, 256'h77,   1'b0,      10, 1'b0);
    txn(1'b0, 1'b1, 1'b0, 27'h200, '0, exp_oor_d, exp_oor_e, 10, 1'b0);

    txn(1'b1, 1'b1, 1'b0, 27'h9, '0,       256'h99,  1'b0, 1, 1'b0);
    txn(1'b1, 1'b0, 1'b1, 27'h9, 256'h123, 256'h123, 1'b0, 1, 1'b0);
    txn(1'b1, 1'b1, 1'b0, 27'h9, '0,       256'h123, 1'b0, 1, 1'b0);

    repeat (15) @(negedge clk);
    chk("scoreboard_drained", LW'(q0.size() + q1.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_line_responder.md
# dmem_line_responder

Responder end of the 256-bit cache-line memory bus driven by the data cache controller (`MEM_ren`/`MEM_wen`/`MEM_addr`/`MEM_wdata` in, `MEM_rdata`/`MEM_ready` out). It holds a line-addressed backing store and services one read or write per transaction after a fixed, parameterised latency, asserting a single-cycle ready pulse at completion. It replaces the ad-hoc memory model at the top level beside `CPU` and is the synthesizable, checkable reference for the cache's miss/write-back handshake.

## Interface
- `LINE_W`, 256, line width in bits
- `ADDR_W`, 27, line address width
- `DEPTH`, 512, number of stored lines (power of two)
- `LATENCY`, 10, cycles from request acceptance to ready (1..255)
- `clk_i` in 1 — clock, all state on rising edge
- `start_i` in 1 — reset, asynchronous, active-low
- `DDATA_ren` in 1 — read request, level, held until ready
- `DDATA_wen` in 1 — write request, level, held until ready
- `DDATA_addr` in `ADDR_W` — line address
- `DDATA_wdata` in `LINE_W` — write line
- `DDATA_rdata` out `LINE_W` — read line, valid while `DDATA_ready`=1, held afterwards
- `DDATA_ready` out 1 — one-cycle completion pulse
- `DDATA_err` out 1 — out-of-range flag, same cycle as `DDATA_ready`

## Operation
- Storage: array `memory[0:DEPTH-1]` of `LINE_W` bits; not reset (bench preloads hierarchically).
- FSM: IDLE, BUSY, DONE.
  - IDLE: if `DDATA_ren|DDATA_wen` at edge, latch addr, wdata, op into request registers; go BUSY with counter=LATENCY-1 (go DONE directly if LATENCY=1).
  - BUSY: decrement counter each edge; at counter==1 go DONE. Input changes ignored.
  - DONE: `DDATA_ready`=1 for this cycle only; next state IDLE unconditionally; requests ignored in DONE.
- Ops on entering DONE (same edge):
  - write: `memory[idx] <= wdata_q`; `DDATA_rdata` <= wdata_q.
  - read: `DDATA_rdata` <= `memory[idx]`.
  - both ren and wen at acceptance: treated as write (write wins).
- idx = `addr_q[log2(DEPTH)-1:0]`; range handling per Configuration.
- `DDATA_rdata` holds its last value outside DONE.

## Timing
- Reset values: state IDLE, `DDATA_ready`=0, `DDATA_rdata`=0, `DDATA_err`=0, counter=0, request registers 0.
- Request sampled at edge E0 → `DDATA_ready` and data high in cycle after edge E0+LATENCY, low after E0+LATENCY+1.
- Back-to-back: a request held through DONE is re-accepted no earlier than the edge ending the first IDLE cycle; min spacing between ready pulses = LATENCY+1 cycles.
- Initiator drops ren/wen on the edge it samples ready=1; responder sees it dropped in IDLE, so no double acceptance.
- `start_i` low mid-transaction: abort immediately, no memory write commits, ready never pulses for that request.
- Throughput: one outstanding request; no pipelining.

## Configuration
- `DMEM_RANGE_CHK_EN` defined: address with any bit set at or above log2(DEPTH) is out of range; read returns all-zero, write is dropped, `DDATA_err`=1 during the DONE cycle; in-range `DDATA_err`=0.
- Not defined: upper address bits ignored (idx wraps modulo DEPTH), `DDATA_err` tied 0.

## Test plan
- Reset with `start_i`=0, preload `memory[0]`=256'h5 → outputs all 0; release, `DDATA_ren`=1 addr 0 at E0 → ready exactly at E0+10, rdata=256'h5, one-cycle pulse.
- Write addr 27'h20 wdata 256'hA5A5 held until ready, then read addr 27'h20 → rdata=256'hA5A5; ready pulses 11 cycles apart minimum.
- Change addr/wdata during BUSY after write acceptance to addr 3 → only originally latched addr 27'h20 updated, `memory[3]` unchanged.
- ren and wen both high addr 5 wdata 256'h1 → `memory[5]`=1, rdata=1 at ready.
- Assert `start_i`=0 at E0+4 of write to addr 7 → no ready, `memory[7]` unchanged, outputs 0.
- Addr 27'h200 read with `DMEM_RANGE_CHK_EN` → rdata=0, err=1; without it → returns `memory[0]`, err=0; rerun with LATENCY=1 → ready at E0+1.
